vert_frame_ctrl: RTL and testbench

Frame-synchronous angle scheduler for the vertex shader. Once per frame, at the frame-start pulse, it advances the rotation angle by a programmable step with wrap at 360. It then fetches the matching cosine from the shared cosine ROM through a request/grant port and presents a stable angle/cosine pair to the shader. The pair changes only once per frame, so the rasteriser never sees mid-frame vertex changes.

---
 rtl/vert_frame_ctrl_if.sv | 25 ++
 rtl/vert_frame_ctrl.sv | 97 +++++++++
 tb/tb_vert_frame_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vert_frame_ctrl_if.sv
// Request/grant/data-valid port between the angle scheduler and the shared cosine ROM arbiter.
// rom_angle is held stable while rom_req is high; rom_cos is qualified by rom_valid.
interface vert_frame_ctrl_if;
  logic              rom_req;
  logic [8:0]        rom_angle;
  logic              rom_gnt;
  logic              rom_valid;
  logic signed [10:0] rom_cos;

  modport master (
    output rom_req,
    output rom_angle,
    input  rom_gnt,
    input  rom_valid,
    input  rom_cos
  );

  modport slave (
    input  rom_req,
    input  rom_angle,
    output rom_gnt,
    output rom_valid,
    output rom_cos
  );
endinterface

// File: rtl/vert_frame_ctrl.sv
// Per-frame angle advance + cosine fetch; commit 1 cycle after rom_valid, min 3 cycles after frame_start.
// Waits indefinitely on grant, re-requests after ROM_TIMEOUT silent cycles; frame_start while busy is dropped and counted.
module vert_frame_ctrl #(
  parameter int ANGLE_MAX   = 360,
  parameter int STEP_W      = 4,
  parameter int ROM_TIMEOUT = 15
) (
  input  logic                clk_pix,
  input  logic                resetn,
  input  logic                frame_start,
  input  logic                pause,
  input  logic [STEP_W-1:0]   step,
  vert_frame_ctrl_if.master   rom,
  output logic [8:0]          angle,
  output logic signed [10:0]  cos,
  output logic                cos_valid,
  output logic                updated,
  output logic                busy,
  output logic [7:0]          overrun_cnt
);

  localparam int TW = $clog2(ROM_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state;
  logic [TW-1:0] tcnt;
  logic [9:0]    inc;
  logic [9:0]    sum;
  logic [8:0]    next_angle;

  assign inc        = pause ? 10'd0 : 10'(step);
  assign sum        = {1'b0, angle} + inc;
  assign next_angle = (sum >= 10'(ANGLE_MAX)) ? 9'(sum - 10'(ANGLE_MAX)) : 9'(sum);

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      tcnt          <= '0;
      angle         <= '0;
      cos           <= '0;
      cos_valid     <= 1'b0;
      updated       <= 1'b0;
      rom.rom_req   <= 1'b0;
      rom.rom_angle <= '0;
      overrun_cnt   <= '0;
    end else begin
      updated <= 1'b0;

      // Dropped frames are only counted; the in-flight fetch is left alone.
      if (frame_start && busy && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            rom.rom_angle <= next_angle;
            rom.rom_req   <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (rom.rom_gnt) begin
            rom.rom_req <= 1'b0;
            tcnt        <= '0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rom.rom_valid) begin
            angle     <= rom.rom_angle;
            cos       <= rom.rom_cos;
            cos_valid <= 1'b1;
            updated   <= 1'b1;
            state     <= S_IDLE;
          end else if (tcnt == TW'(ROM_TIMEOUT - 1)) begin
            // ROM_TIMEOUT silent cycles elapsed: retry with the same angle.
            rom.rom_req <= 1'b1;
            tcnt        <= '0;
            state       <= S_REQ;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          rom.rom_req <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vert_frame_ctrl.sv
// Directed bench for vert_frame_ctrl: expected commits go into a scoreboard queue, a monitor pops them on each updated pulse.
module tb_vert_frame_ctrl;

  logic               clk_pix = 1'b0;
  logic               resetn;
  logic               frame_start;
  logic               pause;
  logic [3:0]         step;
  logic [8:0]         angle;
  logic signed [10:0] cos;
  logic               cos_valid;
  logic               updated;
  logic               busy;
  logic [7:0]         overrun_cnt;

  vert_frame_ctrl_if rif();

  vert_frame_ctrl #(.ANGLE_MAX(360), .STEP_W(4), .ROM_TIMEOUT(15)) dut (
    .clk_pix     (clk_pix),
    .resetn      (resetn),
    .frame_start (frame_start),
    .pause       (pause),
    .step        (step),
    .rom         (rif),
    .angle       (angle),
    .cos         (cos),
    .cos_valid   (cos_valid),
    .updated     (updated),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct packed {
    logic [8:0]         a;
    logic signed [10:0] c;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic wait_req();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_pix);
      if (rif.rom_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rom_req_wait: got 0 expected 1 within 30 cycles");
    end
  endtask

  // One frame with grant in the first REQ cycle and ROM latency of one cycle.
  task automatic run_frame(input logic [3:0] st, input logic p,
                           input logic signed [10:0] cv, input logic [8:0] exp_a);
    sb_q.push_back('{a: exp_a, c: cv});
    step = st;
    pause = p;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_req();
    chk("rom_angle", 32'(rif.rom_angle), 32'(exp_a));
    rif.rom_gnt = 1'b1;
    tick();
    rif.rom_gnt = 1'b0;
    rif.rom_valid = 1'b1;
    rif.rom_cos = cv;
    tick();
    rif.rom_valid = 1'b0;
    tick();
    @(negedge clk_pix);
    chk("busy_after_commit", 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: every updated pulse must match the oldest expected commit.
  always @(negedge clk_pix) begin
    if (resetn && updated) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_update: angle %0d cos %0d with no commit expected", angle, cos);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("commit_angle", 32'(angle), 32'(e.a));
        chk("commit_cos_bits", {21'd0, cos}, {21'd0, e.c});
        chk("commit_cos_valid", 32'(cos_valid), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int model_a;
    resetn = 1'b0;
    frame_start = 1'b0;
    pause = 1'b0;
    step = 4'd0;
    rif.rom_gnt = 1'b0;
    rif.rom_valid = 1'b0;
    rif.rom_cos = '0;

    tick();
    tick();
    @(negedge clk_pix);
    chk("rst_angle", 32'(angle), 32'd0);
    chk("rst_cos", {21'd0, cos}, 32'd0);
    chk("rst_cos_valid", 32'(cos_valid), 32'd0);
    chk("rst_updated", 32'(updated), 32'd0);
    chk("rst_rom_req", 32'(rif.rom_req), 32'd0);
    chk("rst_rom_angle", 32'(rif.rom_angle), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun_cnt), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Basic fetch: 0 + 1 -> 1, cos 1023
    run_frame(4'd1, 1'b0, 11'sd1023, 9'd1);
    chk("t1_angle", 32'(angle), 32'd1);
    chk("t1_cos_valid", 32'(cos_valid), 32'd1);

    // Preload to 358: 1 + 23*15 = 346, then +12
    model_a = 1;
    for (int i = 0; i < 23; i++) begin
      model_a = model_a + 15;
      run_frame(4'd15, 1'b0, 11'(model_a), 9'(model_a));
    end
    run_frame(4'd12, 1'b0, 11'sd400, 9'd358);
    chk("t2_preload", 32'(angle), 32'd358);
    // Wrap: 358 + 3 -> 1
    run_frame(4'd3, 1'b0, -11'sd512, 9'd1);
    chk("t2_wrap_angle", 32'(angle), 32'd1);

    // Pause holds the angle but still fetches
    run_frame(4'd9, 1'b0, 11'sd100, 9'd10);
    run_frame(4'd5, 1'b1, 11'sd200, 9'd10);
    chk("t3_pause_angle", 32'(angle), 32'd10);

    // rom_valid in IDLE is ignored
    tick();
    rif.rom_valid = 1'b1;
    rif.rom_cos = 11'sd7;
    tick();
    rif.rom_valid = 1'b0;
    tick();
    @(negedge clk_pix);
    chk("idle_valid_cos_bits", {21'd0, cos}, 32'd200);
    chk("idle_valid_busy", 32'(busy), 32'd0);

    // Grant withheld 20 cycles, then 15 silent cycles forces a re-request
    sb_q.push_back('{a: 9'd12, c: 11'sd300});
    step = 4'd2;
    pause = 1'b0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_pix);
      chk("t4_req_held", 32'(rif.rom_req), 32'd1);
      chk("t4_angle_held", 32'(rif.rom_angle), 32'd12);
      tick();
    end
    rif.rom_gnt = 1'b1;
    tick();
    rif.rom_gnt = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_pix);
      chk("t4_wait_no_req", 32'(rif.rom_req), 32'd0);
      tick();
    end
    @(negedge clk_pix);
    chk("t4_retry_req", 32'(rif.rom_req), 32'd1);
    chk("t4_retry_angle", 32'(rif.rom_angle), 32'd12);
    rif.rom_gnt = 1'b1;
    tick();
    rif.rom_gnt = 1'b0;
    rif.rom_valid = 1'b1;
    rif.rom_cos = 11'sd300;
    tick();
    rif.rom_valid = 1'b0;
    tick();
    @(negedge clk_pix);
    chk("t4_angle", 32'(angle), 32'd12);

    // Overruns in WAIT and in the commit cycle
    sb_q.push_back('{a: 9'd13, c: 11'sd55});
    step = 4'd1;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_req();
    rif.rom_gnt = 1'b1;
    tick();
    rif.rom_gnt = 1'b0;
    frame_start = 1'b1;
    tick();
    rif.rom_valid = 1'b1;
    rif.rom_cos = 11'sd55;
    tick();
    frame_start = 1'b0;
    rif.rom_valid = 1'b0;
    @(negedge clk_pix);
    chk("t5_overrun2", 32'(overrun_cnt), 32'd2);
    chk("t5_updated", 32'(updated), 32'd1);
    tick();
    tick();
    @(negedge clk_pix);
    chk("t5_single_step", 32'(angle), 32'd13);
    chk("t5_idle", 32'(busy), 32'd0);

    // 300 dropped pulses while stuck in REQ saturate the counter
    sb_q.push_back('{a: 9'd13, c: 11'sd66});
    step = 4'd0;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      if (i == 252) chk("t5_reach_255", 32'(overrun_cnt), 32'd255);
    end
    @(negedge clk_pix);
    chk("t5_saturated", 32'(overrun_cnt), 32'd255);
    chk("t5_req_pending", 32'(rif.rom_req), 32'd1);
    rif.rom_gnt = 1'b1;
    tick();
    rif.rom_gnt = 1'b0;
    rif.rom_valid = 1'b1;
    rif.rom_cos = 11'sd66;
    tick();
    rif.rom_valid = 1'b0;
    tick();
    tick();

    // Reset in WAIT abandons the fetch; late rom_valid is ignored
    step = 4'd1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_req();
    rif.rom_gnt = 1'b1;
    tick();
    rif.rom_gnt = 1'b0;
    @(negedge clk_pix);
    chk("t6_in_wait", 32'(busy), 32'd1);
    tick();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    rif.rom_valid = 1'b1;
    rif.rom_cos = 11'sd99;
    tick();
    rif.rom_valid = 1'b0;
    @(negedge clk_pix);
    chk("t6_no_update", 32'(updated), 32'd0);
    chk("t6_angle", 32'(angle), 32'd0);
    chk("t6_cos_bits", {21'd0, cos}, 32'd0);
    chk("t6_cos_valid", 32'(cos_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rom_req", 32'(rif.rom_req), 32'd0);
    chk("t6_overrun", 32'(overrun_cnt), 32'd0);
    tick();
    tick();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
